// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
// State encoding, config select codes, source indices.
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic CFG_SEL_MASK = 1'b0;
  localparam logic CFG_SEL_GIE  = 1'b1;

  localparam int SRC_INPUT  = 0;
  localparam int SRC_OUTPUT = 1;

endpackage

// File: rtl/int_prio_enc.sv
// Rotating-start priority encoder: first set bit of req at or after base.
// Ports: req (vector), base (start index) -> valid, id.
module int_prio_enc
  import int_ctrl_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] base,
  output logic         valid,
  output logic [W-1:0] id
);

  // Walk offsets from far to near so the nearest hit is written last.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(base) + k) % N]) begin
        valid = 1'b1;
        id    = W'((int'(base) + k) % N);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-latched sources, mask/GIE, one request/ID.
// Ports: clk, rst (async low), src_flag, cfg_*, irq_req/id/ack/done,
// src_clr, gie, mask, pending, in_service, timeout_err.
// Macro INT_CTRL_ROUND_ROBIN_EN selects rotating priority.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int ID_W    = 1,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_flag,
  input  logic               cfg_we,
  input  logic               cfg_sel,
  input  logic [NUM_SRC-1:0] cfg_wdata,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  input  logic               irq_done,
  output logic [NUM_SRC-1:0] src_clr,
  output logic               gie,
  output logic [NUM_SRC-1:0] mask,
  output logic [NUM_SRC-1:0] pending,
  output logic               in_service,
  output logic               timeout_err
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_t state, state_nx;

  logic [NUM_SRC-1:0] flag_q, rise, elig;
  logic [NUM_SRC-1:0] id_oh, clr_vec;
  logic               armed, gie_saved;
  logic               any, cur_ok;
  logic               ack_fire, done_fire, tmo_fire;
  logic               gie_wr, mask_wr;
  logic [TW-1:0]      timer;
  logic               win_valid;
  logic [ID_W-1:0]    win_id, base;

  // armed blocks a flag already high at reset release from
  // looking like a fresh rising edge.
  assign rise    = src_flag & ~flag_q & {NUM_SRC{armed}};
  assign elig    = pending & mask;
  assign any     = gie & (|elig);
  assign cur_ok  = any & elig[irq_id];
  assign id_oh   = NUM_SRC'(1) << irq_id;

  assign ack_fire  = (state == ST_REQ) & cur_ok & irq_ack;
  assign done_fire = (state == ST_SERVICE) & irq_done;
  assign tmo_fire  = (state == ST_SERVICE) & ~irq_done
                   & (timer == T_LAST);

  assign gie_wr  = cfg_we & (cfg_sel == CFG_SEL_GIE);
  assign mask_wr = cfg_we & (cfg_sel == CFG_SEL_MASK);
  assign clr_vec = ack_fire ? id_oh : '0;

`ifdef INT_CTRL_ROUND_ROBIN_EN
  logic [ID_W-1:0] last_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_id <= '0;
    else if (ack_fire) last_id <= irq_id;
  end

  assign base = ID_W'((int'(last_id) + 1) % NUM_SRC);
`else
  assign base = '0;
`endif

  int_prio_enc #(
    .N (NUM_SRC),
    .W (ID_W)
  ) u_enc (
    .req   (elig),
    .base  (base),
    .valid (win_valid),
    .id    (win_id)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (gie & win_valid) state_nx = ST_REQ;
      end
      ST_REQ: begin
        if (!cur_ok)      state_nx = ST_IDLE;
        else if (irq_ack) state_nx = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (done_fire | tmo_fire) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    irq_req    = (state == ST_REQ);
    in_service = (state == ST_SERVICE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_q      <= '0;
      armed       <= 1'b0;
      pending     <= '0;
      src_clr     <= '0;
      mask        <= '0;
      irq_id      <= '0;
      timer       <= '0;
      gie         <= 1'b0;
      gie_saved   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      flag_q  <= src_flag;
      armed   <= 1'b1;
      // A new edge outranks the ack clear on the same bit.
      pending <= (pending & ~clr_vec) | rise;
      src_clr <= clr_vec;
      if (mask_wr) mask <= cfg_wdata;
      if (state == ST_IDLE && gie && win_valid) irq_id <= win_id;

      if (ack_fire)
        timer <= '0;
      else if (state == ST_SERVICE && timer != T_LAST)
        timer <= timer + TW'(1);

      if (ack_fire) begin
        gie_saved <= gie_wr ? cfg_wdata[0] : gie;
        gie       <= 1'b0;
      end else if (done_fire | tmo_fire) begin
        gie <= gie_wr ? cfg_wdata[0] : gie_saved;
        if (gie_wr) gie_saved <= cfg_wdata[0];
      end else if (gie_wr) begin
        if (state == ST_SERVICE) gie_saved <= cfg_wdata[0];
        else                     gie       <= cfg_wdata[0];
      end

      if (tmo_fire)    timeout_err <= 1'b1;
      else if (gie_wr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Interrupt controller for the accumulator CPU.
- Latches I/O interrupt events, applies the mask and global enable, and picks one source.
- Presents a single request/ID to the control block and masks further interrupts while one is serviced.
- Sits between the I/O registers (INPR/OUTR flags) and the control block; it replaces the raw GIE/I_en/O_en/flag wiring.

Parameters:
- NUM_SRC, 2, number of interrupt sources; index 0 = input, 1 = output.
- ID_W, 1, width of irq_id; must satisfy 2**ID_W >= NUM_SRC.
- TIMEOUT, 16, maximum service cycles before forced return; minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset; asserted when 0.
- src_flag  in  NUM_SRC  level flags from the peripherals.
- cfg_we  in  1  configuration write strobe.
- cfg_sel  in  1  0 = mask register, 1 = GIE (bit 0 of cfg_wdata).
- cfg_wdata  in  NUM_SRC  configuration data.
- irq_req  out  1  interrupt request to the control block.
- irq_id  out  ID_W  selected source; valid while irq_req or in_service is high.
- irq_ack  in  1  one-cycle acknowledge, given at an instruction boundary.
- irq_done  in  1  one-cycle end-of-service pulse.
- src_clr  out  NUM_SRC  one-cycle pulse to clear the peripheral flag.
- gie  out  1  current global interrupt enable.
- mask  out  NUM_SRC  per-source enable.
- pending  out  NUM_SRC  latched events.
- in_service  out  1  high in SERVICE.
- timeout_err  out  1  sticky service-timeout flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - state IDLE.
  - gie, gie_saved, mask, pending, flag_q, timer, irq_id, src_clr, timeout_err all 0.
  - irq_req 0, in_service 0.
  - Reset mid-service aborts the service with no done required.
- Edge detection:
  - flag_q <= src_flag every clock.
  - pending[i] is set when src_flag[i] & ~flag_q[i].
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Eligibility: elig = pending & mask; any = gie & |elig.
- IDLE:
  - If any: irq_id <= winner of the priority encode (fixed: lowest index wins), then go to REQ.
- REQ:
  - irq_req = 1.
  - If any drops, or elig[irq_id] drops, before the ack: go to IDLE and deassert irq_req. No pulse is generated.
  - On irq_ack:
    - pending[irq_id] <= 0.
    - src_clr[irq_id] pulses for 1 cycle.
    - gie_saved <= gie, then gie <= 0.
    - timer <= 0, go to SERVICE.
- SERVICE:
  - in_service = 1; timer increments by 1 each cycle.
  - On irq_done: gie <= gie_saved, go to IDLE.
  - If timer == TIMEOUT-1 with no irq_done: timeout_err <= 1, gie <= gie_saved, go to IDLE.
  - If irq_done and the timeout coincide, irq_done wins and no error is raised.
- Ignored inputs:
  - irq_ack outside REQ is ignored.
  - irq_done outside SERVICE is ignored.
- Latency:
  - A flag rises and is sampled at edge k; pending is set at k.
  - irq_req goes high after edge k+1.
  - After the ack at edge a, in_service is high and src_clr is pulsed after edge a.
  - Back-to-back: the next request can rise 1 cycle after leaving SERVICE.
- Configuration writes:
  - A mask write takes effect next cycle in any state.
  - A GIE write in SERVICE updates gie_saved only; in other states it updates gie.
  - Any cfg_sel=1 write clears timeout_err.
- Widths: timer is $clog2(TIMEOUT) bits, with no wrap.

Optional Feature:
- Macro: INT_CTRL_ROUND_ROBIN_EN.
- Defined: rotating priority. A last_id register (reset 0) is updated on each ack. The search starts at last_id+1, modulo NUM_SRC.
- Undefined: fixed priority, lowest index wins; no last_id register.

Decomposition:
- int_ctrl_pkg contains:
  - State encoding: ST_IDLE=2'd0, ST_REQ=2'd1, ST_SERVICE=2'd2.
  - CFG_SEL_MASK=1'b0, CFG_SEL_GIE=1'b1.
  - SRC_INPUT=0, SRC_OUTPUT=1.
- One sub-module, int_prio_enc: combinational encoder with inputs req vector and base index, outputs valid and id. Base is tied to 0 unless round-robin is enabled.

Test Plan:
- Reset, mask=2'b11, gie=1; raise src_flag[0] at cycle 5 -> pending=01 at 5, irq_req=1 and irq_id=0 at 6; ack at 8 -> src_clr=01 for 1 cycle, gie=0, in_service=1; done at 12 -> gie=1, IDLE.
- Both flags rise together, fixed priority -> irq_id=0 first; after done, irq_id=1 served next. With round-robin and last_id=0 -> irq_id=1 first.
- In REQ, clear mask to 00 before the ack -> irq_req drops next cycle, pending stays 01, no src_clr.
- Ack, then withhold irq_done for 16 cycles -> timeout_err=1 at timer 15, gie restored to 1; cfg_sel=1 write clears the error.
- In SERVICE, write GIE=0 -> gie stays 0 after done. src_flag[0] re-rises during ack -> pending[0] remains 1.
- Assert rst=0 mid-SERVICE -> all outputs 0 immediately, without waiting for a clock; flag high at release produces no event until a new rising edge.
